// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Word-addressed data memory that answers CPU load/store requests with a
// configurable number of wait states. Exactly one request is in flight at a
// time: it is accepted on the request channel, held for WAIT_CYCLES extra
// cycles, performed against the array, and then presented on the response
// channel until the requester takes it.
//
// Parameters:
//   DEPTH        number of 32-bit words stored
//   WAIT_CYCLES  extra wait states between acceptance and access (0..15)
//
// Optional feature (compile-time macro):
//   DMEM_ALIGN_CHECK_EN  when defined, a byte address with non-zero low two
//                        bits is rejected as an error; when undefined the low
//                        two bits are ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  responder can accept a request (registered)
//   req_write  1 = store, 0 = load
//   req_addr   byte address, word index = req_addr[31:2]
//   req_wdata  store data
//   rsp_valid  response present
//   rsp_ready  requester accepts the response
//   rsp_rdata  load data; 0 for stores and errors
//   rsp_err    access rejected (out of range, or misaligned when enabled)
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IdxWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          reqWrite_q, reqWrite_d;
  logic [31:0]   reqAddr_q, reqAddr_d;
  logic [31:0]   reqWdata_q, reqWdata_d;
  logic [31:0]   rspRdata_q, rspRdata_d;
  logic          rspErr_q, rspErr_d;
  logic          reqReady_q, reqReady_d;

  logic [31:0]   mem [DEPTH];

  logic [29:0]         wordIdx;
  logic [IdxWidth-1:0] memIdx;
  logic                rangeErr;
  logic                alignErr;
  logic                accessErr;
  logic                memWe;

  // Decode the latched address into a word index and the error conditions.
  // Misalignment outranks the range check, but both collapse into one error.
  assign wordIdx   = reqAddr_q[31:2];
  assign memIdx    = wordIdx[IdxWidth-1:0];
  assign rangeErr  = (wordIdx >= 30'(DEPTH));
`ifdef DMEM_ALIGN_CHECK_EN
  assign alignErr  = (reqAddr_q[1:0] != 2'b00);
`else
  logic unusedAddrLsbs;
  assign unusedAddrLsbs = ^reqAddr_q[1:0];
  assign alignErr  = 1'b0;
`endif
  assign accessErr = alignErr | rangeErr;

  // Next-state logic. The request is latched only on the handshake edge so
  // that anything the requester does while we are busy is ignored. The access
  // itself happens on the edge where the wait counter has reached zero.
  // req_ready is registered and simply tracks whether the next state is IDLE,
  // which makes it drop on the acceptance edge and stay low after reset until
  // the first clock edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    reqWrite_d = reqWrite_q;
    reqAddr_d  = reqAddr_q;
    reqWdata_d = reqWdata_q;
    rspRdata_d = rspRdata_q;
    rspErr_d   = rspErr_q;
    memWe      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && reqReady_q) begin
          reqWrite_d = req_write;
          reqAddr_d  = req_addr;
          reqWdata_d = req_wdata;
          cnt_d      = 4'(WAIT_CYCLES);
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          if (accessErr) begin
            rspRdata_d = 32'd0;
            rspErr_d   = 1'b1;
          end else if (reqWrite_q) begin
            memWe      = 1'b1;
            rspRdata_d = 32'd0;
            rspErr_d   = 1'b0;
          end else begin
            rspRdata_d = mem[memIdx];
            rspErr_d   = 1'b0;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    reqReady_d = (state_d == IDLE);
  end

  // Control and response registers. Reset aborts any in-flight request; since
  // the array is only written on the access edge, a pending store is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      reqWrite_q <= 1'b0;
      reqAddr_q  <= 32'd0;
      reqWdata_q <= 32'd0;
      rspRdata_q <= 32'd0;
      rspErr_q   <= 1'b0;
      reqReady_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      reqWrite_q <= reqWrite_d;
      reqAddr_q  <= reqAddr_d;
      reqWdata_q <= reqWdata_d;
      rspRdata_q <= rspRdata_d;
      rspErr_q   <= rspErr_d;
      reqReady_q <= reqReady_d;
    end
  end

  // Storage array, deliberately without reset so committed stores survive a
  // reset pulse.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memIdx] <= reqWdata_q;
    end
  end

  assign req_ready = reqReady_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rspRdata_q;
  assign rsp_err   = rspErr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//
// Self-checking bench for data_mem_responder. A transaction-level model
// tracks when each accepted request must complete (acceptance edge plus
// WAIT_CYCLES+1) and what it must return, and a compare process checks the
// DUT outputs against it on every falling edge. Directed sequences with
// hand-computed values come first, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

   localparam int DEPTH = 64;
   localparam int WAIT  = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int checkCount = 0;
   int passCount  = 0;

   data_mem_responder #(
      .DEPTH(DEPTH),
      .WAIT_CYCLES(WAIT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Single comparison point: every check in the bench goes through here.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at time %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model. It counts edges and records, for the accepted request,
   // the edge on which the memory access must happen; the model memory keeps
   // a known flag per word so loads of never-written words are not compared.
   logic [31:0] mMem [DEPTH];
   bit          mKnown [DEPTH];
   bit          mReady = 1'b0;
   bit          mBusy = 1'b0;
   bit          mResp = 1'b0;
   logic [31:0] mRdata = 32'd0;
   bit          mErr = 1'b0;
   bit          mRdataKnown = 1'b0;
   longint      edgeNo = 0;
   longint      dueEdge = 0;
   bit          pWrite;
   logic [31:0] pAddr;
   logic [31:0] pWdata;

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mKnown[i] = 1'b0;
         mMem[i]   = 32'd0;
      end
   end

   // Advance the model by one edge, or drop everything on reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mReady = 1'b0;
         mBusy  = 1'b0;
         mResp  = 1'b0;
         mRdata = 32'd0;
         mErr   = 1'b0;
         mRdataKnown = 1'b1;
         edgeNo = 0;
      end else begin
         edgeNo++;
         if (mResp) begin
            if (rsp_ready) begin
               mResp  = 1'b0;
               mReady = 1'b1;
            end
         end else if (mBusy) begin
            if (edgeNo == dueEdge) begin
               int  idx;
               bit  bad;
               idx = int'(pAddr[31:2]);
               bad = (pAddr[31:2] >= DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
               if (pAddr[1:0] != 2'b00) bad = 1'b1;
`endif
               mBusy = 1'b0;
               mResp = 1'b1;
               mErr  = bad;
               mRdata = 32'd0;
               mRdataKnown = 1'b1;
               if (!bad) begin
                  if (pWrite) begin
                     mMem[idx]   = pWdata;
                     mKnown[idx] = 1'b1;
                  end else begin
                     mRdata      = mMem[idx];
                     mRdataKnown = mKnown[idx];
                  end
               end
            end
         end else if (mReady && req_valid) begin
            pWrite  = req_write;
            pAddr   = req_addr;
            pWdata  = req_wdata;
            dueEdge = edgeNo + WAIT + 1;
            mBusy   = 1'b1;
            mReady  = 1'b0;
         end else begin
            mReady = 1'b1;
         end
      end
   end

   // Compare DUT against the model on every falling edge out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("req_ready", {31'd0, req_ready}, {31'd0, mReady});
         checkOutput("rsp_valid", {31'd0, rsp_valid}, {31'd0, mResp});
         if (mResp) begin
            checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, mErr});
            if (mRdataKnown) begin
               checkOutput("rsp_rdata", rsp_rdata, mRdata);
            end
         end
      end
   end

   // Random request-channel noise while the responder is not accepting.
   task automatic scribble();
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_wdata = $urandom;
   endtask

   // One complete transaction: offer the request, wait for the handshake,
   // wait for the response, hold it for 'stall' edges, then accept it.
   // Reports the sampled response and the edge count from acceptance.
   task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                                input int stall, output logic [31:0] rdata, output logic err,
                                output int lat);
      int n;
      rdata = 32'hFFFF_FFFF;
      err   = 1'b1;
      lat   = -1;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checkOutput("handshake_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      lat = 0;
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         scribble();
         if (rsp_valid) break;
         @(posedge clk);
         lat++;
         n++;
      end
      if (!rsp_valid) begin
         checkOutput("response_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      rdata = rsp_rdata;
      err   = rsp_err;
      repeat (stall) begin
         @(negedge clk);
         scribble();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          n;

      // Reset held for three edges: all outputs at their reset values.
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd0);
      checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
      checkOutput("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_release", {31'd0, req_ready}, 32'd1);

      // Store then load with the literal latency of WAIT+1 = 3 edges.
      applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 0, rd, er, lat);
      checkOutput("store_latency", 32'(lat), 32'd3);
      checkOutput("store_err", {31'd0, er}, 32'd0);
      checkOutput("store_rdata", rd, 32'd0);

      // Load under five edges of backpressure.
      applyStimulus(1'b0, 32'h10, 32'd0, 5, rd, er, lat);
      checkOutput("load_latency", 32'(lat), 32'd3);
      checkOutput("load_rdata", rd, 32'hDEAD_BEEF);
      checkOutput("load_err", {31'd0, er}, 32'd0);

      // Out-of-range store must not alias onto word 0.
      applyStimulus(1'b1, 32'h0, 32'hA5A5_A5A5, 1, rd, er, lat);
      applyStimulus(1'b1, 32'h100, 32'h5A5A_5A5A, 0, rd, er, lat);
      checkOutput("range_err", {31'd0, er}, 32'd1);
      checkOutput("range_rdata", rd, 32'd0);
      applyStimulus(1'b0, 32'h0, 32'd0, 0, rd, er, lat);
      checkOutput("word0_kept", rd, 32'hA5A5_A5A5);

      // Misaligned load.
      applyStimulus(1'b0, 32'h12, 32'd0, 0, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
      checkOutput("misaligned_err", {31'd0, er}, 32'd1);
      checkOutput("misaligned_rdata", rd, 32'd0);
`else
      checkOutput("misaligned_err", {31'd0, er}, 32'd0);
      checkOutput("misaligned_rdata", rd, 32'hDEAD_BEEF);
`endif

      // Reset during the wait states of a store drops that store.
      applyStimulus(1'b1, 32'h20, 32'h1111_1111, 0, rd, er, lat);
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h20;
      req_wdata = 32'h1234_5678;
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("midreset_handshake", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midreset_req_ready", {31'd0, req_ready}, 32'd0);
      checkOutput("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      applyStimulus(1'b0, 32'h20, 32'd0, 0, rd, er, lat);
      checkOutput("midreset_store_dropped", rd, 32'h1111_1111);

      // Randomized traffic, mostly to a small window so loads hit stores.
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         if ($urandom_range(0, 9) == 0) begin
            a = {$urandom_range(DEPTH, 4 * DEPTH), 2'b00};
         end else begin
            a = {$urandom_range(0, 15), 2'b00};
         end
         a[1:0] = 2'($urandom_range(0, 3));
         applyStimulus(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), rd, er, lat);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
